sram_axi_bridge: RTL

SRAM_AXI_BRIDGE -- requirements
Module: sram_axi_bridge

---
 rtl/sram_axi_bridge_pkg.sv | 27 ++
 rtl/sram_axi_bridge.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_axi_bridge_pkg.sv
// Shared definitions for the SRAM-like to AXI bridge: FSM encodings,
// AXI ID constants and the fixed burst attributes.
package sram_axi_bridge_pkg;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_AR   = 2'd1,
        R_DATA = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_REQ  = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    localparam logic [3:0] INST_ID    = 4'd0;
    localparam logic [3:0] DATA_ID    = 4'd1;
    localparam logic [7:0] AXI_LEN    = 8'd0;
    localparam logic [1:0] AXI_BURST  = 2'b01;

    // SRAM size codes (byte/half/word) map straight onto AXI size.
    function automatic logic [2:0] axi_size(input logic [1:0] size);
        return {1'b0, size};
    endfunction

endpackage

// File: rtl/sram_axi_bridge.sv
// Bridges the core's inst/data SRAM-like ports onto a single AXI master,
// one read and one write in flight at a time, data port preferred on reads.
module sram_axi_bridge
    import sram_axi_bridge_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,

    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,

    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,

    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,

    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    rd_state_t   rd_state;
    wr_state_t   wr_state;
    logic [31:0] rd_addr;
    logic [1:0]  rd_size;
    logic [3:0]  rd_id;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [1:0]  wr_size;
    logic [3:0]  wr_strb;
    logic        inst_busy;
    logic        data_busy;
    logic        data_rd_req;
    logic        data_rd_accept;
    logic        data_wr_accept;
    logic        raw_block;
    logic        r_hs;
    logic        b_hs;
    logic        unused_inputs;

    assign unused_inputs = ^{rid[3:1], rresp, rlast, bid, bresp, inst_sram_wstrb, inst_sram_wdata};

    // An instruction fetch must not overtake a pending store to the same word.
    assign raw_block   = (wr_state != W_IDLE) && (wr_addr[31:2] == inst_sram_addr[31:2]);
    assign data_rd_req = data_sram_req & ~data_sram_wr;

    assign data_sram_addr_ok = resetn & data_sram_req & ~data_busy
                             & (data_sram_wr ? (wr_state == W_IDLE) : (rd_state == R_IDLE));
    assign inst_sram_addr_ok = resetn & inst_sram_req & ~inst_sram_wr & ~inst_busy
                             & (rd_state == R_IDLE) & ~data_rd_req & ~raw_block;
    assign data_rd_accept    = data_sram_addr_ok & ~data_sram_wr;
    assign data_wr_accept    = data_sram_addr_ok & data_sram_wr;

    assign r_hs = rready & rvalid;
    assign b_hs = bready & bvalid;
    assign inst_sram_data_ok = r_hs & (rid[0] == INST_ID[0]);
    assign data_sram_data_ok = (r_hs & (rid[0] == DATA_ID[0])) | b_hs;
    assign inst_sram_rdata   = rdata;
    assign data_sram_rdata   = rdata;

    assign arid    = rd_id;
    assign araddr  = rd_addr;
    assign arlen   = AXI_LEN;
    assign arsize  = axi_size(rd_size);
    assign arburst = AXI_BURST;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;

    assign awid    = DATA_ID;
    assign awaddr  = wr_addr;
    assign awlen   = AXI_LEN;
    assign awsize  = axi_size(wr_size);
    assign awburst = AXI_BURST;
    assign awlock  = 2'b00;
    assign awcache = 4'b0000;
    assign awprot  = 3'b000;
    assign wid     = DATA_ID;
    assign wdata   = wr_data;
    assign wstrb   = wr_strb;
    assign wlast   = 1'b1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inst_busy <= 1'b0;
            data_busy <= 1'b0;
        end else begin
            if (inst_sram_addr_ok)
                inst_busy <= 1'b1;
            else if (inst_sram_data_ok)
                inst_busy <= 1'b0;
            if (data_sram_addr_ok)
                data_busy <= 1'b1;
            else if (data_sram_data_ok)
                data_busy <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_state <= R_IDLE;
            arvalid  <= 1'b0;
            rready   <= 1'b0;
            rd_addr  <= '0;
            rd_size  <= '0;
            rd_id    <= '0;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (data_rd_accept) begin
                        rd_addr  <= data_sram_addr;
                        rd_size  <= data_sram_size;
                        rd_id    <= DATA_ID;
                        arvalid  <= 1'b1;
                        rd_state <= R_AR;
                    end else if (inst_sram_addr_ok) begin
                        rd_addr  <= inst_sram_addr;
                        rd_size  <= inst_sram_size;
                        rd_id    <= INST_ID;
                        arvalid  <= 1'b1;
                        rd_state <= R_AR;
                    end
                end
                R_AR: begin
                    if (arready) begin
                        arvalid  <= 1'b0;
                        rready   <= 1'b1;
                        rd_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rvalid) begin
                        rready   <= 1'b0;
                        rd_state <= R_IDLE;
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    // AW and W leave together but may be accepted in either order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_state <= W_IDLE;
            awvalid  <= 1'b0;
            wvalid   <= 1'b0;
            bready   <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            wr_size  <= '0;
            wr_strb  <= '0;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    if (data_wr_accept) begin
                        wr_addr  <= data_sram_addr;
                        wr_data  <= data_sram_wdata;
                        wr_size  <= data_sram_size;
                        wr_strb  <= data_sram_wstrb;
                        awvalid  <= 1'b1;
                        wvalid   <= 1'b1;
                        wr_state <= W_REQ;
                    end
                end
                W_REQ: begin
                    if (awready)
                        awvalid <= 1'b0;
                    if (wready)
                        wvalid <= 1'b0;
                    if ((~awvalid | awready) & (~wvalid | wready)) begin
                        bready   <= 1'b1;
                        wr_state <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (bvalid) begin
                        bready   <= 1'b0;
                        wr_state <= W_IDLE;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

endmodule
